mem_stream_reader: RTL

Sequential read initiator for the dual-read-port memory arrays used throughout the simple test designs. On a start request it walks a contiguous, wrapping address range, using both combinational read ports to fetch two words per cycle. It streams the words out as packed beats over a valid/ready interface, with a completion pulse. It is the consumer-side counterpart to the array's write port and drives the array's `raddr1`/`raddr2` inputs directly.

---
 rtl/mem_stream_reader.sv | 76 +++++++
 1 files changed

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: walks a wrapping address range two words per cycle and streams packed beats over valid/ready.
module mem_stream_reader #(
  parameter int ADDR_SIZE = 4,
  parameter int BYTE_SIZE = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [ADDR_SIZE-1:0]   base,
  input  logic [ADDR_SIZE:0]     count,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_SIZE-1:0]   raddr1,
  input  logic [BYTE_SIZE-1:0]   rdata1,
  output logic [ADDR_SIZE-1:0]   raddr2,
  input  logic [BYTE_SIZE-1:0]   rdata2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*BYTE_SIZE-1:0] out_data,
  output logic [1:0]             out_mask,
  output logic                   out_last
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
  localparam logic [ADDR_SIZE:0] ONE = 1;
  localparam logic [ADDR_SIZE:0] TWO = 2;
  state_t               state;
  logic [ADDR_SIZE-1:0] ptr;
  logic [ADDR_SIZE:0]   rem;
  logic                 two;
  logic                 last;
  assign raddr1 = ptr;
  assign raddr2 = ptr + ADDR_SIZE'(1);
  assign two    = rem >= TWO;
  assign last   = rem <= TWO;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      rem       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mask  <= '0;
      out_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          ptr   <= base;
          rem   <= count;
          busy  <= 1'b1;
          done  <= count == '0;
          state <= count != '0 ? RUN : FIN;
        end
        RUN: if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          out_data  <= {two ? rdata2 : '0, rdata1};
          out_mask  <= two ? 2'b11 : 2'b01;
          out_last  <= last;
          ptr       <= ptr + ADDR_SIZE'(2);
          rem       <= rem - (two ? TWO : ONE);
          if (last) state <= DRAIN;
        end
        DRAIN: if (out_valid && out_ready) begin
          out_valid <= 1'b0;
          done      <= 1'b1;
          state     <= FIN;
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule
